// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg -- shared definitions for the reservation stations.
//   label_width() : width of a producer label for a station of given depth
//   NULL_LABEL    : label value meaning "operand value already present"
//   *_STATION_ID  : ids of the ALU and MUL stations (never 0)
// ---------------------------------------------------------------------------
package rs_pkg;

    localparam int NULL_LABEL     = 0;
    localparam int ALU_STATION_ID = 1;
    localparam int MUL_STATION_ID = 2;

    // label = {station id, entry index}
    function automatic int label_width(input int station_w, input int depth);
        return station_w + $clog2(depth);
    endfunction

endpackage

// File: rtl/rs_issue_pick.sv
// ---------------------------------------------------------------------------
// rs_issue_pick -- selects one ready entry of a reservation station.
//   ready : per-entry ready vector
//   age   : (only with RS_AGE_ORDER_EN) age[r][c]=1 means entry c is older
//           than entry r
//   grant : one-hot grant, idx : index of granted entry, valid : any grant
// Build option RS_AGE_ORDER_EN: pick the oldest ready entry; otherwise the
// lowest-index ready entry.
// ---------------------------------------------------------------------------
module rs_issue_pick
    import rs_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            ready,
`ifdef RS_AGE_ORDER_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
`endif
    output logic [DEPTH-1:0]            grant,
    output logic [IDX_W-1:0]            idx,
    output logic                        valid
);

    logic [DEPTH-1:0] cand;

`ifdef RS_AGE_ORDER_EN
    // An entry is a candidate when no ready entry is older than it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_cand
        assign cand[gi] = ready[gi] & ~|(age[gi] & ready);
    end
`else
    assign cand = ready;
`endif

    // Lowest-index candidate; keeps the grant strictly one-hot.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && !valid) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/age_res_station.sv
// ---------------------------------------------------------------------------
// age_res_station -- Tomasulo reservation station with DEPTH entries.
// Holds renamed instructions, snoops the CDB for missing operands and
// presents one ready entry per cycle to its functional unit. An issued entry
// stays busy until its own label is broadcast on the CDB.
//
// Ports:
//   clk, nRST (async, active-low)
//   WEN, opCode, dataIn1/2, label1/2 : insert from CU (label 0 = value valid)
//   BCEN, BClabel, BCdata            : CDB broadcast
//   EXEable                          : functional unit accepts an issue
//   flush                            : kill all entries
//   OutEn, opOut, dataOut1/2, ready_labelOut : presented ready entry
//   writeable_labelOut               : label the next insert will take
//   isFull, count                    : occupancy
//
// Build option RS_AGE_ORDER_EN: issue the oldest ready entry (age matrix);
// undefined: issue the lowest-index ready entry.
// ---------------------------------------------------------------------------
module age_res_station
    import rs_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int DATA_W     = 32,
    parameter  int OP_W       = 3,
    parameter  int STATION_W  = 2,
    parameter  int STATION_ID = ALU_STATION_ID,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int LABEL_W    = label_width(STATION_W, DEPTH)
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               WEN,
    input  logic [OP_W-1:0]    opCode,
    input  logic [DATA_W-1:0]  dataIn1,
    input  logic [DATA_W-1:0]  dataIn2,
    input  logic [LABEL_W-1:0] label1,
    input  logic [LABEL_W-1:0] label2,
    input  logic               BCEN,
    input  logic [LABEL_W-1:0] BClabel,
    input  logic [DATA_W-1:0]  BCdata,
    input  logic               EXEable,
    input  logic               flush,
    output logic [OP_W-1:0]    opOut,
    output logic [DATA_W-1:0]  dataOut1,
    output logic [DATA_W-1:0]  dataOut2,
    output logic               OutEn,
    output logic [LABEL_W-1:0] ready_labelOut,
    output logic [LABEL_W-1:0] writeable_labelOut,
    output logic               isFull,
    output logic [IDX_W:0]     count
);

    localparam logic [STATION_W-1:0] SID = STATION_W'(STATION_ID);

    logic [DEPTH-1:0]   busy_reg, busy_next;
    logic [DEPTH-1:0]   issued_reg, issued_next;
    logic [DEPTH-1:0]   ready;

    logic [OP_W-1:0]    op_arr [DEPTH];
    logic [LABEL_W-1:0] qj_arr [DEPTH];
    logic [LABEL_W-1:0] qk_arr [DEPTH];
    logic [DATA_W-1:0]  vj_arr [DEPTH];
    logic [DATA_W-1:0]  vk_arr [DEPTH];

    logic [IDX_W-1:0]   slot_idx;
    logic [IDX_W:0]     count_val;
    logic               full;
    logic               do_insert;
    logic               snoop_valid;
    logic               free_hit;
    logic [IDX_W-1:0]   free_idx;
    logic               do_issue;

    logic [DEPTH-1:0]   pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    // ------------------------------------------------------------------
    // Insert slot: lowest-index free entry (0 when full).
    // ------------------------------------------------------------------
    always_comb begin
        slot_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_reg[i]) slot_idx = IDX_W'(i);
        end
    end

    always_comb begin
        count_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_val = count_val + {{IDX_W{1'b0}}, busy_reg[i]};
        end
    end

    assign full        = &busy_reg;
    assign do_insert   = WEN & ~full & ~flush;
    assign snoop_valid = BCEN & (BClabel != LABEL_W'(NULL_LABEL));
    assign free_hit    = snoop_valid & (BClabel[LABEL_W-1:IDX_W] == SID);
    assign free_idx    = BClabel[IDX_W-1:0];
    assign do_issue    = pick_valid & EXEable;

    // ------------------------------------------------------------------
    // Per-entry payload and ready detection. Payload is not reset: it is
    // only observed while the entry is busy, and insert overwrites it.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
        logic [OP_W-1:0]    op_reg;
        logic [LABEL_W-1:0] qj_reg, qk_reg;
        logic [DATA_W-1:0]  vj_reg, vk_reg;

        always_ff @(posedge clk) begin
            if (do_insert && slot_idx == IDX_W'(gi)) begin
                op_reg <= opCode;
                // An operand whose producer broadcasts this very cycle is
                // captured directly from the CDB.
                if (snoop_valid && label1 == BClabel) begin
                    qj_reg <= '0;
                    vj_reg <= BCdata;
                end else begin
                    qj_reg <= label1;
                    vj_reg <= dataIn1;
                end
                if (snoop_valid && label2 == BClabel) begin
                    qk_reg <= '0;
                    vk_reg <= BCdata;
                end else begin
                    qk_reg <= label2;
                    vk_reg <= dataIn2;
                end
            end else if (snoop_valid && busy_reg[gi]) begin
                if (qj_reg == BClabel) begin
                    qj_reg <= '0;
                    vj_reg <= BCdata;
                end
                if (qk_reg == BClabel) begin
                    qk_reg <= '0;
                    vk_reg <= BCdata;
                end
            end
        end

        assign op_arr[gi] = op_reg;
        assign qj_arr[gi] = qj_reg;
        assign qk_arr[gi] = qk_reg;
        assign vj_arr[gi] = vj_reg;
        assign vk_arr[gi] = vk_reg;

        assign ready[gi] = busy_reg[gi] & ~issued_reg[gi] &
                           (qj_reg == '0) & (qk_reg == '0);
    end

    // ------------------------------------------------------------------
    // Busy / Issued bookkeeping. Freeing only touches a busy entry, and the
    // insert slot is always a non-busy one, so the two never collide.
    // ------------------------------------------------------------------
    always_comb begin
        busy_next   = busy_reg;
        issued_next = issued_reg;
        if (flush) begin
            busy_next   = '0;
            issued_next = '0;
        end else begin
            if (do_issue) issued_next = issued_reg | pick_grant;
            if (free_hit && busy_reg[free_idx]) begin
                busy_next[free_idx]   = 1'b0;
                issued_next[free_idx] = 1'b0;
            end
            if (do_insert) begin
                busy_next[slot_idx]   = 1'b1;
                issued_next[slot_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy_reg   <= '0;
            issued_reg <= '0;
        end else begin
            busy_reg   <= busy_next;
            issued_reg <= issued_next;
        end
    end

`ifdef RS_AGE_ORDER_EN
    // ------------------------------------------------------------------
    // Age matrix: age_reg[r][c]=1 means entry c is older than entry r.
    // Inserting into slot s writes row s with the current busy vector and
    // clears column s, so a recycled slot is never seen as older than
    // entries that were already waiting.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][DEPTH-1:0] age_reg;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            age_reg <= '0;
        end else if (do_insert) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (IDX_W'(r) == slot_idx) age_reg[r] <= busy_reg;
                else                      age_reg[r][slot_idx] <= 1'b0;
            end
        end
    end
`endif

    rs_issue_pick #(
        .DEPTH (DEPTH)
    ) u_pick (
        .ready (ready),
`ifdef RS_AGE_ORDER_EN
        .age   (age_reg),
`endif
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // ------------------------------------------------------------------
    // Outputs (combinational from registered state)
    // ------------------------------------------------------------------
    assign OutEn              = pick_valid;
    assign opOut              = pick_valid ? op_arr[pick_idx] : '0;
    assign dataOut1           = pick_valid ? vj_arr[pick_idx] : '0;
    assign dataOut2           = pick_valid ? vk_arr[pick_idx] : '0;
    assign ready_labelOut     = {SID, (pick_valid ? pick_idx : IDX_W'(0))};
    assign writeable_labelOut = {SID, slot_idx};
    assign isFull             = full;
    assign count              = count_val;

endmodule
